i2c_target_controller: RTL and testbench
========================================

// Module: i2c_target_controller
// PURPOSE
// - I2C target (slave) controller: far end of the bus from the I2C master controller in this design.
// - Detects START/STOP, receives the address byte, ACKs its own 7-bit address, then receives bytes
//   (write) or transmits bytes (read). SCL is sampled on the system clock; SDA is open-drain via SDA_OE.
// - Byte-level handshake to user logic: RX_DATA/RX_VALID for writes, TX_DATA/TX_REQ for reads.
// - No clock stretching.
// PARAMETERS
// - ADDR        7'h48  own 7-bit target address
// - SYNC_STAGES 2      flops in the SCL/SDA input synchronisers (>=2)
// PORTS
// - CLK         in   1  system clock, sole clock; CLK must be >= 10x the SCL frequency
// - RESET       in   1  asynchronous, active-low reset
// - SCL         in   1  bus clock pin (input only)
// - SDA_IN      in   1  bus data pin, read side
// - SDA_OE      out  1  1 = pull SDA low; 0 = release SDA (pull-up gives 1)
// - TX_DATA     in   8  byte to send on reads; sampled when the byte is loaded
// - RX_READY    in   1  1 = accept the incoming write byte (ACK); 0 = NACK it
// - RX_DATA     out  8  last received write byte; holds until the next byte completes
// - RX_VALID    out  1  1-CLK pulse when RX_DATA updates
// - TX_REQ      out  1  1-CLK pulse requesting the next TX_DATA byte
// - ADDR_MATCH  out  1  1-CLK pulse when the address byte matches ADDR
// - RW          out  1  R/W bit of the last matched address (1 = read)
// - BUSY        out  1  1 from a START until a STOP (or reset)
// BEHAVIOUR
// - Reset (RESET=0, async): all outputs 0, RX_DATA=8'h00, state IDLE, bit counter 0, SDA released at once.
// - Input path: SYNC_STAGES-flop sync, then a registered edge detect. Pin-to-decision latency is
//   SYNC_STAGES+1 CLK.
// - Events (synced, CLK domain):
//   - SCL rise: sample a bit.
//   - SCL fall: update SDA_OE.
//   - START: SDA fall while SCL=1.
//   - STOP: SDA rise while SCL=1.
//   - START/STOP take priority over any SCL event in the same cycle.
// - START from any state (including repeated START mid-byte): go to ADDR, counter 0, SDA_OE=0,
//   BUSY=1. A partial byte is discarded.
// - STOP from any state: go to IDLE, SDA_OE=0 next CLK, BUSY=0.
// - ADDR: shift in 8 bits MSB-first on SCL rises. After the 8th rise:
//   - match (byte[7:1]==ADDR): latch RW=byte[0], pulse ADDR_MATCH; go to ADDR_ACK.
//   - no match: go to WAIT_STOP with SDA released; nothing else asserts.
// - ADDR_ACK: SDA_OE=1 from the next SCL fall until the SCL fall after the 9th rise.
//   - RW=0: go to RX_BYTE.
//   - RW=1: pulse TX_REQ on the 9th rise; load TX_DATA on the following fall; go to TX_BYTE.
// - RX_BYTE: shift 8 bits. After the 8th rise:
//   - RX_DATA <= byte, pulse RX_VALID.
//   - RX_READY=1 at that CLK: ACK (SDA_OE=1 across the 9th clock, released on its falling edge), then RX_BYTE.
//   - RX_READY=0 at that CLK: NACK (SDA stays released), then WAIT_STOP.
// - TX_BYTE: on each SCL fall drive SDA_OE = ~bit, MSB first. On the fall after the 8th rise, release SDA.
//   At the 9th rise, sample SDA:
//   - 0 (master ACK): pulse TX_REQ, load TX_DATA on the next fall, continue in TX_BYTE.
//   - 1 (master NACK): go to WAIT_STOP with no TX_REQ.
// - WAIT_STOP: SDA released; ignore SCL; leave only on START or STOP.
// - IDLE: SDA released; SCL edges ignored.
// - Bit counter is 4-bit, 0..8, cleared on START and at each byte boundary. It never wraps past 8.
// - Single-cycle pulses never stretch; RW and RX_DATA hold across STOP until overwritten.
// TESTING
// 1. START, 0x90, 0xA5, RX_READY=1, STOP -> ACK on both 9th clocks, ADDR_MATCH x1, RW=0,
//    RX_VALID x1 with RX_DATA=0xA5, BUSY high from START to STOP.
// 2. START, 0x92, 0x55, STOP -> SDA_OE never 1, no ADDR_MATCH/RX_VALID, BUSY=0 after STOP.
// 3. START, 0x91, TX_DATA=0x3C then 0xC3, master ACK then NACK, STOP -> SDA carries 0x3C then 0xC3,
//    TX_REQ x2, SDA released after the NACK.
// 4. Write 0x90, 0x11 (RX_READY=1), 0x22 (RX_READY=0) -> ACK 0x11, NACK 0x22, RX_VALID x2,
//    later bytes ignored until STOP.
// 5. Repeated START after 4 bits of a write byte, then 0x91 -> partial byte dropped, no RX_VALID,
//    read phase begins with ADDR_MATCH and RW=1.
// 6. RESET low while SDA_OE=1 mid-read -> SDA_OE=0 with no CLK edge, state IDLE, BUSY=0.

Source files
------------

// File: rtl/i2c_target_controller.sv
// I2C target: synchronises SCL/SDA, decodes START/STOP, ACKs its own address and
// moves bytes to/from user logic with a one-byte handshake. No clock stretching.
module i2c_target_controller #(
    parameter logic [6:0] ADDR        = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       rx_ready_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       tx_req_o,
    output logic       addr_match_o,
    output logic       rw_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_BYTE,
        ACK,
        RX_BYTE,
        TX_BYTE,
        WAIT_STOP
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclPrev_q;
    logic                   sdaPrev_q;
    logic [3:0]             bitCnt_q;
    logic [6:0]             shift_q;
    logic                   sdaOe_q;
    logic [7:0]             rxData_q;
    logic                   rxValid_q;
    logic                   txReq_q;
    logic                   addrMatch_q;
    logic                   rw_q;
    logic                   busy_q;

    logic       sclS;
    logic       sdaS;
    logic       sclRise;
    logic       sclFall;
    logic       startEv;
    logic       stopEv;
    logic [7:0] rxByte_d;

    // The bus idles high, so synchronisers reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_i};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_i};
            sclPrev_q <= sclS;
            sdaPrev_q <= sdaS;
        end
    end

    assign sclS     = sclSync_q[SYNC_STAGES-1];
    assign sdaS     = sdaSync_q[SYNC_STAGES-1];
    assign sclRise  = sclS & ~sclPrev_q;
    assign sclFall  = ~sclS & sclPrev_q;
    assign startEv  = sclS & sclPrev_q & sdaPrev_q & ~sdaS;
    assign stopEv   = sclS & sclPrev_q & ~sdaPrev_q & sdaS;
    assign rxByte_d = {shift_q, sdaS};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= 4'd0;
            shift_q     <= 7'd0;
            sdaOe_q     <= 1'b0;
            rxData_q    <= 8'h00;
            rxValid_q   <= 1'b0;
            txReq_q     <= 1'b0;
            addrMatch_q <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rxValid_q   <= 1'b0;
            txReq_q     <= 1'b0;
            addrMatch_q <= 1'b0;
            if (startEv) begin
                state_q  <= ADDR_BYTE;
                bitCnt_q <= 4'd0;
                sdaOe_q  <= 1'b0;
                busy_q   <= 1'b1;
            end else if (stopEv) begin
                state_q  <= IDLE;
                bitCnt_q <= 4'd0;
                sdaOe_q  <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    ADDR_BYTE: begin
                        if (sclRise) begin
                            shift_q  <= rxByte_d[6:0];
                            bitCnt_q <= bitCnt_q + 4'd1;
                            if (bitCnt_q == 4'd7) begin
                                if (rxByte_d[7:1] == ADDR) begin
                                    rw_q        <= rxByte_d[0];
                                    addrMatch_q <= 1'b1;
                                    state_q     <= ACK;
                                end else begin
                                    state_q <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    // Shared by the address and write-data ACKs; rw_q is 0 for the latter.
                    ACK: begin
                        if (sclFall) begin
                            sdaOe_q <= 1'b1;
                        end else if (sclRise) begin
                            bitCnt_q <= 4'd0;
                            if (rw_q) begin
                                txReq_q <= 1'b1;
                                state_q <= TX_BYTE;
                            end else begin
                                state_q <= RX_BYTE;
                            end
                        end
                    end
                    RX_BYTE: begin
                        if (sclFall) begin
                            sdaOe_q <= 1'b0;
                        end else if (sclRise) begin
                            shift_q  <= rxByte_d[6:0];
                            bitCnt_q <= bitCnt_q + 4'd1;
                            if (bitCnt_q == 4'd7) begin
                                rxData_q  <= rxByte_d;
                                rxValid_q <= 1'b1;
                                state_q   <= rx_ready_i ? ACK : WAIT_STOP;
                            end
                        end
                    end
                    // Count 0 on a fall means a fresh byte; 8 means the master's ACK slot.
                    TX_BYTE: begin
                        if (sclFall) begin
                            if (bitCnt_q == 4'd0) begin
                                shift_q <= tx_data_i[6:0];
                                sdaOe_q <= ~tx_data_i[7];
                            end else if (bitCnt_q == 4'd8) begin
                                sdaOe_q <= 1'b0;
                            end else begin
                                shift_q <= {shift_q[5:0], 1'b0};
                                sdaOe_q <= ~shift_q[6];
                            end
                        end else if (sclRise) begin
                            if (bitCnt_q == 4'd8) begin
                                bitCnt_q <= 4'd0;
                                if (!sdaS) begin
                                    txReq_q <= 1'b1;
                                end else begin
                                    state_q <= WAIT_STOP;
                                end
                            end else begin
                                bitCnt_q <= bitCnt_q + 4'd1;
                            end
                        end
                    end
                    default: begin
                        sdaOe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe_o     = sdaOe_q;
    assign rx_data_o    = rxData_q;
    assign rx_valid_o   = rxValid_q;
    assign tx_req_o     = txReq_q;
    assign addr_match_o = addrMatch_q;
    assign rw_o         = rw_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_target_controller.sv
// Bench for i2c_target_controller: a bit-banged I2C master drives the bus while a
// scoreboard queue checks the target's handshake pulses as they appear.
module tb_i2c_target_controller;

    localparam int Q = 6;
    localparam logic [1:0] EV_ADDR  = 2'd1;
    localparam logic [1:0] EV_RX    = 2'd2;
    localparam logic [1:0] EV_TXREQ = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       masterLow = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       rxReady = 1'b1;
    logic       sdaLine;
    logic       sdaOe;
    logic [7:0] rxData;
    logic       rxValid;
    logic       txReq;
    logic       addrMatch;
    logic       rw;
    logic       busy;

    evt_t       expQ[$];
    logic [7:0] txBytes[$];
    int         checks = 0;
    int         failures = 0;
    logic       oeSeen = 1'b0;

    assign sdaLine = ~(sdaOe | masterLow);

    always #5 clk = ~clk;

    i2c_target_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scl_i        (scl),
        .sda_i        (sdaLine),
        .sda_oe_o     (sdaOe),
        .tx_data_i    (txData),
        .rx_ready_i   (rxReady),
        .rx_data_o    (rxData),
        .rx_valid_o   (rxValid),
        .tx_req_o     (txReq),
        .addr_match_o (addrMatch),
        .rw_o         (rw),
        .busy_o       (busy)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic popCheck(input string name, input evt_t actual);
        evt_t exp;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: unexpected event %0h with nothing expected", name, actual);
        end else begin
            exp = expQ.pop_front();
            checkOutput(name, {6'b0, actual}, {6'b0, exp});
        end
    endtask

    // Monitor: every handshake pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (addrMatch) popCheck("addrMatch", {EV_ADDR, 7'b0, rw});
            if (rxValid)   popCheck("rxValid", {EV_RX, rxData});
            if (txReq)     popCheck("txReq", {EV_TXREQ, 8'h00});
            if (sdaOe)     oeSeen = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (txReq && txBytes.size() > 0) txData = txBytes.pop_front();
    end

    task automatic waitQ();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic bitVal, output logic sampled);
        waitQ();
        masterLow = ~bitVal;
        waitQ();
        scl = 1'b1;
        waitQ();
        sampled = sdaLine;
        waitQ();
        scl = 1'b0;
    endtask

    task automatic busStart();
        waitQ();
        masterLow = 1'b0;
        waitQ();
        scl = 1'b1;
        waitQ();
        masterLow = 1'b1;
        waitQ();
        scl = 1'b0;
    endtask

    task automatic busStop();
        waitQ();
        masterLow = 1'b1;
        waitQ();
        scl = 1'b1;
        waitQ();
        masterLow = 1'b0;
        waitQ();
    endtask

    task automatic sendByte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) applyStimulus(b[i], s);
        applyStimulus(1'b1, s);
        acked = ~s;
    endtask

    task automatic readByte(input logic ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, s);
            b[i] = s;
        end
        applyStimulus(~ack, s);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] rd;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetSdaOe", {15'b0, sdaOe}, 16'd0);
        checkOutput("resetRxData", {8'b0, rxData}, 16'h0000);
        checkOutput("resetPulses", {13'b0, rxValid, txReq, addrMatch}, 16'd0);
        checkOutput("resetBusyRw", {14'b0, busy, rw}, 16'd0);
        rst_n = 1'b1;
        waitQ();

        $display("[TB] test 1: write 0xA5");
        expQ.push_back({EV_ADDR, 8'h00});
        expQ.push_back({EV_RX, 8'hA5});
        busStart();
        checkOutput("t1BusyAfterStart", {15'b0, busy}, 16'd1);
        sendByte(8'h90, ack);
        checkOutput("t1AddrAck", {15'b0, ack}, 16'd1);
        sendByte(8'hA5, ack);
        checkOutput("t1DataAck", {15'b0, ack}, 16'd1);
        checkOutput("t1BusyBeforeStop", {15'b0, busy}, 16'd1);
        busStop();
        checkOutput("t1BusyAfterStop", {15'b0, busy}, 16'd0);
        checkOutput("t1RxDataHeld", {8'b0, rxData}, 16'h00A5);
        checkOutput("t1Rw", {15'b0, rw}, 16'd0);

        $display("[TB] test 2: foreign address 0x92");
        oeSeen = 1'b0;
        busStart();
        sendByte(8'h92, ack);
        checkOutput("t2AddrNack", {15'b0, ack}, 16'd0);
        sendByte(8'h55, ack);
        checkOutput("t2DataNack", {15'b0, ack}, 16'd0);
        busStop();
        checkOutput("t2OeNeverDriven", {15'b0, oeSeen}, 16'd0);
        checkOutput("t2BusyAfterStop", {15'b0, busy}, 16'd0);
        checkOutput("t2RxDataUnchanged", {8'b0, rxData}, 16'h00A5);

        $display("[TB] test 3: read 0x3C, 0xC3");
        txBytes.push_back(8'h3C);
        txBytes.push_back(8'hC3);
        expQ.push_back({EV_ADDR, 8'h01});
        expQ.push_back({EV_TXREQ, 8'h00});
        expQ.push_back({EV_TXREQ, 8'h00});
        busStart();
        sendByte(8'h91, ack);
        checkOutput("t3AddrAck", {15'b0, ack}, 16'd1);
        readByte(1'b1, rd);
        checkOutput("t3Byte0", {8'b0, rd}, 16'h003C);
        readByte(1'b0, rd);
        checkOutput("t3Byte1", {8'b0, rd}, 16'h00C3);
        waitQ();
        checkOutput("t3ReleasedAfterNack", {15'b0, sdaOe}, 16'd0);
        busStop();
        checkOutput("t3Rw", {15'b0, rw}, 16'd1);

        $display("[TB] test 4: write with NACK");
        expQ.push_back({EV_ADDR, 8'h00});
        expQ.push_back({EV_RX, 8'h11});
        expQ.push_back({EV_RX, 8'h22});
        busStart();
        sendByte(8'h90, ack);
        checkOutput("t4AddrAck", {15'b0, ack}, 16'd1);
        rxReady = 1'b1;
        sendByte(8'h11, ack);
        checkOutput("t4Ack11", {15'b0, ack}, 16'd1);
        rxReady = 1'b0;
        sendByte(8'h22, ack);
        checkOutput("t4Nack22", {15'b0, ack}, 16'd0);
        rxReady = 1'b1;
        sendByte(8'h33, ack);
        checkOutput("t4Ignored33", {15'b0, ack}, 16'd0);
        busStop();
        checkOutput("t4RxDataLast", {8'b0, rxData}, 16'h0022);

        $display("[TB] test 5: repeated START mid-byte");
        txBytes.push_back(8'h5A);
        expQ.push_back({EV_ADDR, 8'h00});
        busStart();
        sendByte(8'h90, ack);
        checkOutput("t5AddrWrAck", {15'b0, ack}, 16'd1);
        applyStimulus(1'b0, s);
        applyStimulus(1'b1, s);
        applyStimulus(1'b1, s);
        applyStimulus(1'b1, s);
        expQ.push_back({EV_ADDR, 8'h01});
        expQ.push_back({EV_TXREQ, 8'h00});
        busStart();
        sendByte(8'h91, ack);
        checkOutput("t5AddrRdAck", {15'b0, ack}, 16'd1);
        checkOutput("t5Rw", {15'b0, rw}, 16'd1);
        readByte(1'b0, rd);
        checkOutput("t5Byte", {8'b0, rd}, 16'h005A);
        busStop();
        checkOutput("t5RxDataKept", {8'b0, rxData}, 16'h0022);

        $display("[TB] test 6: reset mid-read");
        txBytes.push_back(8'h00);
        expQ.push_back({EV_ADDR, 8'h01});
        expQ.push_back({EV_TXREQ, 8'h00});
        busStart();
        sendByte(8'h91, ack);
        checkOutput("t6AddrAck", {15'b0, ack}, 16'd1);
        applyStimulus(1'b1, s);
        waitQ();
        checkOutput("t6OeDrivenBeforeReset", {15'b0, sdaOe}, 16'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t6OeAsyncReset", {15'b0, sdaOe}, 16'd0);
        checkOutput("t6BusyAsyncReset", {15'b0, busy}, 16'd0);
        checkOutput("t6RwAsyncReset", {15'b0, rw}, 16'd0);
        checkOutput("t6RxDataAsyncReset", {8'b0, rxData}, 16'h0000);
        scl = 1'b1;
        masterLow = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        waitQ();
        expQ.push_back({EV_ADDR, 8'h00});
        busStart();
        sendByte(8'h90, ack);
        checkOutput("t6AckAfterReset", {15'b0, ack}, 16'd1);
        busStop();
        checkOutput("t6BusyEnd", {15'b0, busy}, 16'd0);

        waitQ();
        checkOutput("scoreboardDrained", expQ.size(), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
